// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// CPU instruction-fetch port and the data port. It grants one request at a
// time, round-robin when both are pending, and holds the memory strobes for
// LATENCY cycles. One cycle after the access ends, it returns a one-cycle ack
// to the port that was granted.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    // The access counter runs from LATENCY-1 down to 0, so ACCESS lasts exactly LATENCY cycles.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    port_e         last_grant_q, last_grant_d;   // also identifies the port owning the current access
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_re_q, mem_re_d;
    logic          mem_we_q, mem_we_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;
    logic          grant_data_s;

    // Next-state logic: arbitration in IDLE, latency countdown in ACCESS, ack in DONE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = mem_re_q;
        mem_we_d     = mem_we_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        grant_data_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    // With both pending, the port that did not win last time goes next.
                    grant_data_s = d_req && (!if_req || (last_grant_q == PORT_INSTR));
                    state_d      = ST_ACCESS;
                    cnt_d        = CNT_LOAD;
                    if (grant_data_s) begin
                        last_grant_d = PORT_DATA;
                        mem_addr_d   = d_addr;
                        mem_wdata_d  = d_wdata;
                        mem_we_d     = d_we;
                        mem_re_d     = ~d_we;
                    end else begin
                        last_grant_d = PORT_INSTR;
                        mem_addr_d   = if_addr;
                        mem_we_d     = 1'b0;
                        mem_re_d     = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Read data is only guaranteed valid in the final access cycle.
                    if (mem_re_q) begin
                        if (last_grant_q == PORT_DATA) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    mem_re_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ST_DONE;
                    if (last_grant_q == PORT_DATA) begin
                        d_ack_d = 1'b1;
                    end else begin
                        if_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                // Ack is visible this cycle; no grant is made until IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= PORT_INSTR;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-schedule reference model predicts
// every output cycle by cycle from the grant time of the current access.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_re, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req1;
    logic        if_ack1, d_ack1, mem_re1, mem_we1, busy1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(L)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(32'h0000_0100), .if_ack(if_ack1), .if_rdata(if_rdata1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_rdata(mem_rdata1), .busy(busy1)
    );

    // Memory contents before any write
    function automatic logic [31:0] init_val(input logic [7:0] idx);
        if (idx == 8'd4) return 32'hDEAD_BEEF;
        return {idx, ~idx, idx ^ 8'h3C, 8'h5A};
    endfunction

    // Behavioural memory seen by the DUT
    logic [31:0] mem [256];
    bit          wr_valid [256];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:2]]      <= mem_wdata;
            wr_valid[mem_addr[9:2]] <= 1'b1;
        end
    end
    assign mem_rdata  = wr_valid[mem_addr[9:2]] ? mem[mem_addr[9:2]] : init_val(mem_addr[9:2]);
    assign mem_rdata1 = ~mem_addr1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: the latest granted access and when it was granted
    bit          cur_v, cur_data, cur_we, last_data;
    int          cur_s, free_c;
    logic [31:0] cur_addr, cur_wdata, cur_rval;
    logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
    logic [31:0] ref_val [256];
    bit          ref_wr [256];
    bit          m_if_ack, m_d_ack;
    bit          p5_on;
    int          p5_c0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    task automatic model_reset();
        cur_v = 1'b0; last_data = 1'b0; free_c = 0;
        e_if_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
        m_if_ack = 1'b0; m_d_ack = 1'b0;
    endtask

    // Decide the grant for the requests the DUT samples at the end of this cycle
    task automatic model_sample();
        bit pick;
        int idx;
        if (cyc >= free_c && (if_req || d_req)) begin
            pick      = d_req && (!if_req || !last_data);
            cur_v     = 1'b1;
            cur_s     = cyc;
            cur_data  = pick;
            cur_we    = pick && d_we;
            cur_addr  = pick ? d_addr : if_addr;
            cur_wdata = d_wdata;
            idx       = int'(cur_addr[9:2]);
            if (cur_we) begin
                ref_val[idx] = d_wdata;
                ref_wr[idx]  = 1'b1;
            end
            cur_rval  = ref_wr[idx] ? ref_val[idx] : init_val(8'(idx));
            last_data = pick;
            free_c    = cyc + L + 2;
        end
    endtask

    // Advance one cycle and compare every output with the schedule
    task automatic step_check();
        bit in_acc, ack, e_busy;
        int k;
        @(posedge clk);
        #1;
        cyc++;
        in_acc   = cur_v && (cyc >= cur_s + 1) && (cyc <= cur_s + L);
        ack      = cur_v && (cyc == cur_s + L + 1);
        e_busy   = cur_v && (cyc >= cur_s + 1) && (cyc <= cur_s + L + 1);
        m_if_ack = ack && !cur_data;
        m_d_ack  = ack && cur_data;
        if (cur_v && cyc == cur_s + 1) begin
            e_mem_addr = cur_addr;
            if (cur_data) e_mem_wdata = cur_wdata;
        end
        if (ack && !cur_we) begin
            if (cur_data) e_d_rdata = cur_rval;
            else          e_if_rdata = cur_rval;
        end
        check_val("if_ack",    32'(if_ack),   32'(m_if_ack));
        check_val("d_ack",     32'(d_ack),    32'(m_d_ack));
        check_val("mem_re",    32'(mem_re),   32'(in_acc && !cur_we));
        check_val("mem_we",    32'(mem_we),   32'(in_acc && cur_we));
        check_val("busy",      32'(busy),     32'(e_busy));
        check_val("mem_addr",  mem_addr,      e_mem_addr);
        check_val("mem_wdata", mem_wdata,     e_mem_wdata);
        check_val("if_rdata",  if_rdata,      e_if_rdata);
        check_val("d_rdata",   d_rdata,       e_d_rdata);
        check_val("ack_pair",  32'(if_ack & d_ack),  32'd0);
        check_val("strb_pair", 32'(mem_re & mem_we), 32'd0);
        if (p5_on) begin
            k = cyc - p5_c0;
            check_val("l1_if_ack", 32'(if_ack1), 32'((k % 3) == 2));
            check_val("l1_mem_re", 32'(mem_re1), 32'((k % 3) == 1));
            check_val("l1_rdata",  if_rdata1, (k >= 2) ? 32'hFFFF_FEFF : 32'h0);
        end
    endtask

    // Requester behaviour: 0 drop on ack, 1 random, 2 keep both requesting
    task automatic apply_policy(input int mode);
        if (m_if_ack) begin
            if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
                if_req = 1'b1;
                if (mode == 1) if_addr = rand_addr();
            end else begin
                if_req = 1'b0;
            end
        end else if (mode == 1 && !if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = rand_addr();
        end
        if (m_d_ack) begin
            if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
                d_req = 1'b1;
                if (mode == 1) begin
                    d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
                end
            end else begin
                d_req = 1'b0;
            end
        end else if (mode == 1 && !d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end
    endtask

    task automatic cycle(input int mode);
        step_check();
        apply_policy(mode);
        model_sample();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_if_ack"}, 32'(if_ack), 32'd0);
        check_val({tag, "_d_ack"},  32'(d_ack),  32'd0);
        check_val({tag, "_re"},     32'(mem_re), 32'd0);
        check_val({tag, "_we"},     32'(mem_we), 32'd0);
        check_val({tag, "_busy"},   32'(busy),   32'd0);
        check_val({tag, "_addr"},   mem_addr,    32'd0);
        check_val({tag, "_wdata"},  mem_wdata,   32'd0);
        check_val({tag, "_ifrd"},   if_rdata,    32'd0);
        check_val({tag, "_drd"},    d_rdata,     32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        model_sample();
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock edge
    task automatic do_reset(input bit hold);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst");
        if (!hold) begin
            if_req = 1'b0;
            d_req  = 1'b0;
        end
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req1 = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; p5_on = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("init");
        release_reset();

        // Single fetch of 0x10
        step_check();
        if_req = 1'b1; if_addr = 32'h10;
        model_sample();
        repeat (L + 3) cycle(0);
        check_val("t1_rdata", if_rdata, 32'hDEAD_BEEF);

        // Single data write of 0x1234 to 0x40
        step_check();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234;
        model_sample();
        repeat (L + 3) cycle(0);
        check_val("t2_mem", mem[16], 32'h1234);

        // Both ports requesting from reset: data first, then alternating
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        do_reset(1'b1);
        repeat (16) cycle(2);
        repeat (8) cycle(0);

        // Reset during the second access cycle of a fetch, then a clean fetch
        step_check();
        if_req = 1'b1; if_addr = 32'h20;
        model_sample();
        cycle(0);
        cycle(0);
        do_reset(1'b0);
        step_check();
        if_req = 1'b1; if_addr = 32'h30;
        model_sample();
        repeat (L + 3) cycle(0);

        // Data request arriving while a fetch is in ACCESS
        step_check();
        if_req = 1'b1; if_addr = 32'h44;
        model_sample();
        cycle(0);
        step_check();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        model_sample();
        repeat (8) cycle(0);

        // LATENCY=1 instance with a continuous fetch request
        step_check();
        if_req1 = 1'b1;
        p5_c0 = cyc;
        p5_on = 1'b1;
        model_sample();
        repeat (15) cycle(0);

        // Randomized traffic on the main instance
        repeat (400) cycle(1);
        repeat (10) cycle(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
